// File: rtl/pipe_skid_chain_pkg.sv
// Shared types and helpers for the skid-buffer pipeline chain.
// Used by pipe_skid_stage and pipe_skid_chain.
package pipe_pkg;

  // Occupancy counter width for a chain of n stages, each holding up to 2 beats.
  function automatic int occ_width(input int n);
    return $clog2(2 * n + 1);
  endfunction

  // Per-cycle fire combination, encoded as {in_fire, out_fire}.
  typedef enum logic [1:0] {
    FIRE_NONE = 2'b00,
    FIRE_OUT  = 2'b01,
    FIRE_IN   = 2'b10,
    FIRE_BOTH = 2'b11
  } fire_e;

endpackage

// File: rtl/pipe_skid_stage.sv
// One full-throughput skid stage: main register plus skid register.
// in_ready and out_valid are both taken straight from flops.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit RESET_DATA = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic                  r_main_v;
  logic                  r_skid_v;
  logic [DATA_WIDTH-1:0] r_main_d;
  logic [DATA_WIDTH-1:0] r_skid_d;

  logic                  w_in_fire;
  logic                  w_out_fire;
  fire_e                 w_fire;
  logic                  w_main_v_nxt;
  logic                  w_skid_v_nxt;
  logic [DATA_WIDTH-1:0] w_main_d_nxt;
  logic [DATA_WIDTH-1:0] w_skid_d_nxt;

  assign in_ready   = ~r_skid_v;
  assign out_valid  = r_main_v;
  assign out_data   = r_main_d;
  assign w_in_fire  = in_valid & ~r_skid_v;
  assign w_out_fire = r_main_v & out_ready;
  assign w_fire     = fire_e'({w_in_fire, w_out_fire});

  // Next-state of both registers; skid always drains into main first to keep order.
  always_comb begin
    w_main_v_nxt = r_main_v;
    w_skid_v_nxt = r_skid_v;
    w_main_d_nxt = r_main_d;
    w_skid_d_nxt = r_skid_d;
    case (w_fire)
      FIRE_BOTH: begin
        w_main_v_nxt = 1'b1;
        if (r_skid_v) begin
          w_main_d_nxt = r_skid_d;
          w_skid_d_nxt = in_data;
        end else begin
          w_main_d_nxt = in_data;
        end
      end
      FIRE_IN: begin
        if (!r_main_v) begin
          w_main_v_nxt = 1'b1;
          if (r_skid_v) begin
            w_main_d_nxt = r_skid_d;
            w_skid_d_nxt = in_data;
          end else begin
            w_main_d_nxt = in_data;
          end
        end else begin
          w_skid_v_nxt = 1'b1;
          w_skid_d_nxt = in_data;
        end
      end
      FIRE_OUT: begin
        w_skid_v_nxt = 1'b0;
        if (r_skid_v) begin
          w_main_d_nxt = r_skid_d;
        end else begin
          w_main_v_nxt = 1'b0;
        end
      end
      default: ;
    endcase
    if (flush) begin
      w_main_v_nxt = 1'b0;
      w_skid_v_nxt = 1'b0;
    end
  end

  // Valid bits: async reset, synchronous flush folded into next-state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else begin
      r_main_v <= w_main_v_nxt;
      r_skid_v <= w_skid_v_nxt;
    end
  end

  generate
    if (RESET_DATA) begin : g_data_rst
      // Payload registers cleared on reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_main_d <= '0;
          r_skid_d <= '0;
        end else begin
          r_main_d <= w_main_d_nxt;
          r_skid_d <= w_skid_d_nxt;
        end
      end
    end else begin : g_data_norst
      // Payload registers left unreset; valid bits alone qualify them.
      always_ff @(posedge clk) begin
        r_main_d <= w_main_d_nxt;
        r_skid_d <= w_skid_d_nxt;
      end
    end
  endgenerate

endmodule

// File: rtl/pipe_skid_chain.sv
// Cascade of NUM_STAGES skid stages with synchronous flush.
// Optional occupancy counter and its consistency assertion: define PIPE_OCC_EN.
module pipe_skid_chain
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_STAGES = 2,
  parameter bit RESET_DATA = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef PIPE_OCC_EN
  ,
  output logic [occ_width(NUM_STAGES)-1:0] occupancy
`endif
);

  // Link k is the input side of stage k; link NUM_STAGES is the chain output.
  logic                  w_valid [0:NUM_STAGES];
  logic                  w_ready [0:NUM_STAGES];
  logic [DATA_WIDTH-1:0] w_data  [0:NUM_STAGES];

  assign w_valid[0]          = in_valid;
  assign w_data[0]           = in_data;
  assign in_ready            = w_ready[0];
  assign out_valid           = w_valid[NUM_STAGES];
  assign out_data            = w_data[NUM_STAGES];
  assign w_ready[NUM_STAGES] = out_ready;

  generate
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      pipe_skid_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_DATA (RESET_DATA)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (w_valid[k]),
        .in_ready  (w_ready[k]),
        .in_data   (w_data[k]),
        .out_valid (w_valid[k+1]),
        .out_ready (w_ready[k+1]),
        .out_data  (w_data[k+1])
      );
    end
  endgenerate

`ifdef PIPE_OCC_EN
  localparam int OW = occ_width(NUM_STAGES);

  logic [OW-1:0] r_occ;
  logic [OW-1:0] w_vsum;
  fire_e         w_fire;

  assign w_fire    = fire_e'({in_valid & w_ready[0], out_valid & out_ready});
  assign occupancy = r_occ;

  // Beat counter: +1 per accepted beat, -1 per delivered beat, cleared by flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else begin
      case (w_fire)
        FIRE_IN:  r_occ <= r_occ + {{(OW-1){1'b0}}, 1'b1};
        FIRE_OUT: r_occ <= r_occ - {{(OW-1){1'b0}}, 1'b1};
        default:  r_occ <= r_occ;
      endcase
    end
  end

  // Sum of every valid bit in the chain; a stage's skid is valid exactly when its in_ready is low.
  always_comb begin
    w_vsum = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      w_vsum = w_vsum + {{(OW-1){1'b0}}, w_valid[k+1]} + {{(OW-1){1'b0}}, ~w_ready[k]};
    end
  end

  a_occ_matches_valids: assert property (@(posedge clk) disable iff (rst) r_occ == w_vsum);
`endif

endmodule

// File: tb/tb_pipe_skid_chain.sv
// Self-checking bench for pipe_skid_chain (NUM_STAGES=2); occupancy checks under PIPE_OCC_EN.
module tb_pipe_skid_chain;

  localparam int DW = 32;
  localparam int NS = 2;
  localparam int OW = $clog2(2 * NS + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
`ifdef PIPE_OCC_EN
  logic [OW-1:0] occupancy;
`endif

  int vectors     = 0;
  int miscompares = 0;
  logic [DW-1:0] q[$];

  pipe_skid_chain #(
    .DATA_WIDTH (DW),
    .NUM_STAGES (NS),
    .RESET_DATA (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_OCC_EN
    ,
    .occupancy (occupancy)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard monitor, sampled on the falling edge between active edges.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
`ifdef PIPE_OCC_EN
      vectors++;
      if (occupancy !== OW'(q.size())) begin
        miscompares++;
        $display("FAIL occupancy: got %0d expected %0d at %0t", occupancy, q.size(), $time);
      end
`endif
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready) begin
          vectors++;
          if (q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_underflow: got %h with nothing expected at %0t", out_data, $time);
          end else begin
            logic [DW-1:0] exp_d;
            exp_d = q.pop_front();
            if (out_data !== exp_d) begin
              miscompares++;
              $display("FAIL sb_data: got %h expected %h at %0t", out_data, exp_d, $time);
            end
          end
        end
        if (in_valid && in_ready) q.push_back(in_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++;
    if (out_data !== '0) begin miscompares++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
`ifdef PIPE_OCC_EN
    vectors++;
    if (occupancy !== '0) begin miscompares++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
`endif
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      in_valid = (k <= 8);
      in_data  = DW'(k);
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready: cycle %0d got %b expected 1", k, in_ready); end
      step();
      vectors++;
      if (out_valid !== (k >= 2 && k <= 9)) begin
        miscompares++;
        $display("FAIL stream_out_valid: cycle %0d got %b expected %b", k, out_valid, (k >= 2 && k <= 9));
      end
      if (k >= 2 && k <= 9) begin
        vectors++;
        if (out_data !== DW'(k - 1)) begin
          miscompares++;
          $display("FAIL stream_out_data: cycle %0d got %h expected %h", k, out_data, k - 1);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int cnt;
    logic acc;
    cnt = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = DW'(32'hA0 + cnt);
      acc = in_ready;
      step();
      if (acc) cnt++;
    end
    in_data = DW'(32'hA0 + cnt);
    vectors++;
    if (cnt != 4) begin miscompares++; $display("FAIL bp_accepted: got %0d expected 4", cnt); end
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
`ifdef PIPE_OCC_EN
    vectors++;
    if (occupancy !== OW'(4)) begin miscompares++; $display("FAIL bp_occ: got %0d expected 4", occupancy); end
`endif
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== DW'(32'hA0)) begin
        miscompares++;
        $display("FAIL bp_hold: got v=%b d=%h expected v=1 d=a0", out_valid, out_data);
      end
      step();
    end
  endtask

  task automatic test_drain_one();
    int t;
    in_valid  = 1'b1;
    in_data   = DW'(32'hA4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== DW'(32'hA1)) begin
      miscompares++;
      $display("FAIL drain1_head: got v=%b d=%h expected v=1 d=a1", out_valid, out_data);
    end
    t = 0;
    while (!in_ready && t < 4) begin step(); t++; end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL drain1_ready_return: got %b expected 1", in_ready); end
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      t = 0;
      while (!out_valid && t < 8) begin step(); t++; end
      vectors++;
      if (out_valid !== 1'b1 || out_data !== DW'(32'hA1 + j)) begin
        miscompares++;
        $display("FAIL drain1_order: beat %0d got v=%b d=%h expected %h", j, out_valid, out_data, 32'hA1 + j);
      end
      step();
    end
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drain1_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_random();
    int accepted;
    int cyc;
    logic acc;
    accepted = 0;
    cyc = 0;
    while (accepted < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 1) == 1);
      acc = in_valid && in_ready;
      step();
      if (acc) accepted++;
      cyc++;
    end
    vectors++;
    if (accepted != 10000) begin miscompares++; $display("FAIL rand_budget: got %0d beats expected 10000", accepted); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (q.size() != 0 && cyc < 20) begin step(); cyc++; end
    step();
    vectors++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rand_drain: got %0d pending v=%b expected 0 pending v=0", q.size(), out_valid);
    end
  endtask

  task automatic test_flush();
    int t;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(32'h10 + i);
      step();
    end
    flush    = 1'b1;
    in_data  = DW'(32'hEE);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_clear: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
    end
`ifdef PIPE_OCC_EN
    vectors++;
    if (occupancy !== '0) begin miscompares++; $display("FAIL flush_occ: got %0d expected 0", occupancy); end
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_discard: got v=%b expected 0", out_valid); end
    end
    in_valid  = 1'b1;
    in_data   = DW'(32'h55);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 8) begin step(); t++; end
    vectors++;
    if (out_valid !== 1'b1 || out_data !== DW'(32'h55)) begin
      miscompares++;
      $display("FAIL flush_next: got v=%b d=%h expected v=1 d=55", out_valid, out_data);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int t;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(32'h30 + i);
      step();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_async: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
    end
`ifdef PIPE_OCC_EN
    vectors++;
    if (occupancy !== '0) begin miscompares++; $display("FAIL rstmid_occ: got %0d expected 0", occupancy); end
`endif
    step();
    step();
    rst = 1'b0;
    step();
    in_valid  = 1'b1;
    in_data   = DW'(32'h77);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 8) begin step(); t++; end
    vectors++;
    if (out_valid !== 1'b1 || out_data !== DW'(32'h77)) begin
      miscompares++;
      $display("FAIL rstmid_first: got v=%b d=%h expected v=1 d=77", out_valid, out_data);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_drain_one();
    test_random();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
